// File: rtl/qix_pkg.sv
// qix_pkg: shared video timing defaults, palette byte layout (RRGGBBII) and decode helper.
`default_nettype none

package qix_pkg;

  localparam int H_TOTAL_DEF  = 320;
  localparam int V_TOTAL_DEF  = 264;
  localparam int HS_START_DEF = 272;
  localparam int VS_START_DEF = 260;
  localparam int H_ACTIVE     = 256;
  localparam int V_ACTIVE_DEF = 256;
  localparam int HS_WIDTH     = 32;
  localparam int VS_LINES     = 3;

  localparam int PAL_RR_LSB = 6;
  localparam int PAL_GG_LSB = 4;
  localparam int PAL_BB_LSB = 2;
  localparam int PAL_II_LSB = 0;

  typedef struct packed {
    logic hs;
    logic vs;
    logic hb;
    logic vb;
  } sync_t;

  localparam sync_t SYNC_RST = '{hs: 1'b0, vs: 1'b0, hb: 1'b1, vb: 1'b1};

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // The two intensity bits are shared as the low half of every channel.
  function automatic rgb_t pal_decode(input logic [7:0] p);
    rgb_t c;
    c.r = {p[PAL_RR_LSB +: 2], p[PAL_II_LSB +: 2]};
    c.g = {p[PAL_GG_LSB +: 2], p[PAL_II_LSB +: 2]};
    c.b = {p[PAL_BB_LSB +: 2], p[PAL_II_LSB +: 2]};
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/qix_palette_ram.sv
// qix_palette_ram: 1024x8 dual-port palette; CPU port read/write (write-first), display port read-only.
`default_nettype none

module qix_palette_ram (
  input  logic       clk,
  input  logic       cpu_we_i,
  input  logic [9:0] cpu_addr_i,
  input  logic [7:0] cpu_din_i,
  output logic [7:0] cpu_dout_o,
  input  logic [9:0] disp_addr_i,
  output logic [7:0] disp_dout_o
);

  logic [7:0] mem_q [0:1023];
  logic [7:0] cpu_dout_q;
  logic [7:0] disp_dout_q;

  // On an address collision the display port returns the pre-write byte.
  always_ff @(posedge clk) begin
    if (cpu_we_i) begin
      mem_q[cpu_addr_i] <= cpu_din_i;
    end
    cpu_dout_q  <= cpu_we_i ? cpu_din_i : mem_q[cpu_addr_i];
    disp_dout_q <= mem_q[disp_addr_i];
  end

  assign cpu_dout_o  = cpu_dout_q;
  assign disp_dout_o = disp_dout_q;

endmodule

`default_nettype wire

// File: rtl/qix_scanout.sv
// qix_scanout: raster counters, 3-stage framebuffer->palette->RGB pipeline with aligned syncs.
// Optional test pattern on the stage-2 pixel when QIX_SCANOUT_TESTPAT_EN is defined.
`default_nettype none

module qix_scanout
  import qix_pkg::*;
#(
  parameter int H_TOTAL  = H_TOTAL_DEF,
  parameter int V_TOTAL  = V_TOTAL_DEF,
  parameter int HS_START = HS_START_DEF,
  parameter int VS_START = VS_START_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic        clk,
  input  logic        reset,
`ifdef QIX_SCANOUT_TESTPAT_EN
  input  logic        testpat,
`endif
  input  logic        ce_pix,
  output logic [15:0] display_addr,
  input  logic [7:0]  display_dout,
  input  logic [1:0]  pal_bank,
  input  logic        pal_we,
  input  logic [9:0]  pal_addr,
  input  logic [7:0]  pal_din,
  output logic [7:0]  pal_dout,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        hsync,
  output logic        vsync,
  output logic        hblank,
  output logic        vblank
);

  localparam int HW = ($clog2(H_TOTAL) > 8) ? $clog2(H_TOTAL) : 8;
  localparam int VW = ($clog2(V_TOTAL) > 8) ? $clog2(V_TOTAL) : 8;

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [15:0]   addr_q;
  logic [7:0]    pix_q, pix_d;
  logic [1:0]    bank_q;
  logic [7:0]    pal_rd;
  rgb_t          rgb_q, pal_rgb;
  sync_t         sync_d;
  sync_t [2:0]   dly_q;

  always_comb begin
    hcnt_d = hcnt_q + HW'(1);
    vcnt_d = vcnt_q;
    if (hcnt_q == HW'(H_TOTAL - 1)) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == VW'(V_TOTAL - 1)) ? '0 : vcnt_q + VW'(1);
    end
  end

  always_comb begin
    sync_d.hs = (hcnt_q >= HW'(HS_START)) && (hcnt_q < HW'(HS_START + HS_WIDTH));
    sync_d.vs = (vcnt_q >= VW'(VS_START)) && (vcnt_q < VW'(VS_START + VS_LINES));
    sync_d.hb = (hcnt_q >= HW'(H_ACTIVE));
    sync_d.vb = (vcnt_q >= VW'(V_ACTIVE));
  end

  always_comb begin
    pix_d = display_dout;
`ifdef QIX_SCANOUT_TESTPAT_EN
    // addr_q still holds the coordinates of the pixel entering stage 2.
    if (testpat) begin
      pix_d = {addr_q[3] ^ addr_q[11], 7'h7F};
    end
`endif
  end

  assign pal_rgb = pal_decode(pal_rd);

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      addr_q <= '0;
      pix_q  <= '0;
      bank_q <= '0;
      rgb_q  <= '0;
      dly_q  <= {3{SYNC_RST}};
    end else if (ce_pix) begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      addr_q <= {vcnt_q[7:0], hcnt_q[7:0]};
      pix_q  <= pix_d;
      dly_q  <= {dly_q[1:0], sync_d};
      // dly_q[1] belongs to the same pixel whose palette byte is in pal_rd.
      rgb_q  <= (dly_q[1].hb || dly_q[1].vb) ? rgb_t'('0) : pal_rgb;
      if ((vcnt_q == VW'(VS_START)) && (hcnt_q == '0)) begin
        bank_q <= pal_bank;
      end
    end
  end

  qix_palette_ram u_pal (
    .clk         (clk),
    .cpu_we_i    (pal_we),
    .cpu_addr_i  (pal_addr),
    .cpu_din_i   (pal_din),
    .cpu_dout_o  (pal_dout),
    .disp_addr_i ({bank_q, pix_q}),
    .disp_dout_o (pal_rd)
  );

  assign display_addr = addr_q;
  assign r      = rgb_q.r;
  assign g      = rgb_q.g;
  assign b      = rgb_q.b;
  assign hsync  = dly_q[2].hs;
  assign vsync  = dly_q[2].vs;
  assign hblank = dly_q[2].hb;
  assign vblank = dly_q[2].vb;

endmodule

`default_nettype wire

// File: tb/tb_qix_scanout.sv
// tb_qix_scanout: scoreboard bench; expected pixels are queued by the stimulus and popped by a ce_pix monitor.
`default_nettype none

module tb_qix_scanout;

  localparam int HT    = 320;
  localparam int VT    = 16;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce_pix = 1'b0;
  logic [15:0] display_addr;
  logic [7:0]  display_dout = 8'h00;
  logic [1:0]  pal_bank;
  logic        pal_we;
  logic [9:0]  pal_addr;
  logic [7:0]  pal_din;
  logic [7:0]  pal_dout;
  logic [3:0]  r, g, b;
  logic        hsync, vsync, hblank, vblank;
`ifdef QIX_SCANOUT_TESTPAT_EN
  logic        testpat = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int ce_n  = 0;

  typedef struct {
    int          idx;
    int          h;
    int          v;
    int          f;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];

  qix_scanout #(
    .H_TOTAL  (HT),
    .V_TOTAL  (VT),
    .HS_START (272),
    .VS_START (12),
    .V_ACTIVE (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef QIX_SCANOUT_TESTPAT_EN
    .testpat      (testpat),
`endif
    .ce_pix       (ce_pix),
    .display_addr (display_addr),
    .display_dout (display_dout),
    .pal_bank     (pal_bank),
    .pal_we       (pal_we),
    .pal_addr     (pal_addr),
    .pal_din      (pal_din),
    .pal_dout     (pal_dout),
    .r            (r),
    .g            (g),
    .b            (b),
    .hsync        (hsync),
    .vsync        (vsync),
    .hblank       (hblank),
    .vblank       (vblank)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    ce_pix = ~ce_pix;
  end

  // Framebuffer model: one-clock read latency, byte equals the low address byte.
  always @(posedge clk) display_dout <= display_addr[7:0];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input int h, input int v, input int f,
                      input logic [3:0] er, input logic [3:0] eg, input logic [3:0] eb,
                      input logic hs, input logic vs, input logic hb, input logic vb);
    exp_t e;
    e.idx = f * FRAME + v * HT + h + 1;
    e.h   = h;
    e.v   = v;
    e.f   = f;
    e.val = {er, eg, eb, hs, vs, hb, vb};
    sb.push_back(e);
  endtask

  task automatic pal_write(input logic [9:0] a, input logic [7:0] d);
    @(negedge clk);
    pal_we   = 1'b1;
    pal_addr = a;
    pal_din  = d;
    @(negedge clk);
    pal_we   = 1'b0;
  endtask

  task automatic wait_ce(input int target);
    int guard = 0;
    while (ce_n < target && guard < 40000) begin
      @(posedge clk);
      guard++;
    end
    if (ce_n < target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_ce: reached %0d expected %0d", ce_n, target);
    end
  endtask

  // Monitor: one output pixel per ce_pix; pixel n appears after the (n+2)-th ce.
  initial begin
    int   last_rise = -1;
    logic prev_hs   = 1'b0;
    exp_t e;
    forever begin
      @(posedge clk);
      if (reset) begin
        ce_n = 0;
      end else if (ce_pix) begin
        ce_n++;
        #1;
        if (ce_n == 1)    chk("addr_first", 32'(display_addr), 32'h0000);
        if (ce_n == 2)    chk("addr_second", 32'(display_addr), 32'h0001);
        if (ce_n == 322)  chk("addr_line1", 32'(display_addr), 32'h0101);
        if (ce_n == 2561) chk("addr_line8", 32'(display_addr), 32'h0800);
        if (hsync && !prev_hs) begin
          if (last_rise >= 0) chk("line_period", 32'(ce_n - last_rise), 32'(HT));
          last_rise = ce_n;
        end
        prev_hs = hsync;
        while (sb.size() > 0 && sb[0].idx + 2 < ce_n) begin
          e = sb.pop_front();
          n_cmp++;
          n_bad++;
          $display("FAIL pix_missed h=%0d v=%0d f=%0d", e.h, e.v, e.f);
        end
        if (sb.size() > 0 && sb[0].idx + 2 == ce_n) begin
          e = sb.pop_front();
          chk($sformatf("pix h=%0d v=%0d f=%0d {rgb,hs,vs,hb,vb}", e.h, e.v, e.f),
              32'({r, g, b, hsync, vsync, hblank, vblank}), 32'(e.val));
        end
      end
    end
  end

  initial begin
    reset    = 1'b1;
    pal_we   = 1'b0;
    pal_addr = '0;
    pal_din  = '0;
    pal_bank = 2'd0;

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_addr",  32'(display_addr), 32'h0);
    chk("rst_rgb",   32'({r, g, b}), 32'h0);
    chk("rst_sync",  32'({hsync, vsync}), 32'h0);
    chk("rst_blank", 32'({hblank, vblank}), 32'h3);

    pal_write(10'h000, 8'hC3);
    pal_write(10'h001, 8'h30);
    pal_write(10'h005, 8'h0E);
    pal_write(10'h0FF, 8'h55);
    pal_write(10'h200, 8'h3C);
    pal_write(10'h201, 8'hC0);
    pal_write(10'h3FF, 8'hA5);
    @(negedge clk);
    chk("cpu_readback", 32'(pal_dout), 32'hA5);

    //    h    v  f   r     g     b    hs    vs    hb    vb
    push(0,   0, 0, 4'hF, 4'h3, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1,   0, 0, 4'h0, 4'hC, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(5,   0, 0, 4'h2, 4'h2, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0);
    push(255, 0, 0, 4'h5, 4'h5, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
    push(256, 0, 0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    push(271, 0, 0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    push(272, 0, 0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    push(303, 0, 0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    push(304, 0, 0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    push(0,   1, 0, 4'hF, 4'h3, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    reset = 1'b0;

    // Bank request mid-frame: the rest of this frame must still use bank 0.
    wait_ce(4 * HT + 1);
    @(negedge clk);
    pal_bank = 2'd2;
    push(0,   5, 0, 4'hF, 4'h3, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
    push(0,   7, 0, 4'hF, 4'h3, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
    push(0,   8, 0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(1,  11, 0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(0,  12, 0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    push(0,  15, 0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(0,   0, 1, 4'h0, 4'hC, 4'hC, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1,   0, 1, 4'hC, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    wait_ce(FRAME + 2 + 2 + 1);
    chk("sb_drained", 32'(sb.size()), 32'h0);

    @(negedge clk);
    reset    = 1'b1;
    pal_addr = 10'h3FF;
    repeat (3) @(negedge clk);
    chk("pal_kept_after_reset", 32'(pal_dout), 32'hA5);
    chk("rst2_rgb", 32'({r, g, b}), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
